// File: rtl/mfp_uart_load_controller.sv
// Purpose : parse UART load packets (SYNC, ADDR x4, COUNT, N words LE, CSUM) into 32-bit word writes.
// Latency : a write is presented the cycle after the 4th byte of its word; done pulses the cycle after CSUM (or after the last write drains).
// Backpress: one write outstanding; a word completing while the previous one is still unaccepted is an overrun (word dropped, packet aborted).
//
// Ports:
//   clock, reset_n          clock, asynchronous active-low reset
//   byte_data, byte_ready   received byte stream, 1-cycle strobe per byte
//   wr_addr, wr_data,       word write request, held stable while wr_valid=1,
//   wr_valid, wr_ready      accepted when wr_valid & wr_ready
//   busy                    packet in progress (state != IDLE), registered
//   done                    1-cycle pulse at packet end (also on checksum failure)
//   err_checksum/overrun/timeout  sticky error flags, cleared by the next SYNC byte
module mfp_uart_load_controller #(
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 5000000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [7:0]  byte_data,
  input  logic        byte_ready,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic        busy,
  output logic        done,
  output logic        err_checksum,
  output logic        err_overrun,
  output logic        err_timeout
);

  localparam int TW = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMER_RELOAD = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMER_ONE    = TW'(1);

  typedef enum logic [2:0] {IDLE, ADDR, COUNT, DATA, CSUM, DRAIN, ABORT} state_t;

  state_t        state;
  logic [1:0]    byte_idx;
  logic [31:0]   base_addr;
  logic [8:0]    word_total;   // 1..256
  logic [7:0]    word_idx;
  logic [23:0]   word_sr;      // first three bytes of the word being assembled
  logic [7:0]    csum;
  logic [TW-1:0] timer;

  logic          timed_state;
  logic          timer_expired;
  logic          last_word;
  logic          wr_stalled;
  logic [31:0]   next_word;
  logic [31:0]   next_addr;
  logic [7:0]    csum_next;

  assign timed_state   = (state == ADDR) || (state == COUNT) || (state == DATA) || (state == CSUM);
  // Expire on the cycle the count would reach zero, i.e. exactly TIMEOUT_CYCLES
  // clocks after the last reload.
  assign timer_expired = (timer == TIMER_ONE);
  assign last_word     = ({1'b0, word_idx} == (word_total - 9'd1));
  // A write that is pending and not being accepted this cycle.
  assign wr_stalled    = wr_valid && !wr_ready;
  assign next_word     = {byte_data, word_sr};
  // Low two bits of base ride through untouched; sum wraps mod 2^32.
  assign next_addr     = base_addr + {22'd0, word_idx, 2'b00};
  assign csum_next     = csum + byte_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      byte_idx     <= 2'd0;
      base_addr    <= 32'd0;
      word_total   <= 9'd0;
      word_idx     <= 8'd0;
      word_sr      <= 24'd0;
      csum         <= 8'd0;
      timer        <= '0;
      wr_addr      <= 32'd0;
      wr_data      <= 32'd0;
      wr_valid     <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      err_checksum <= 1'b0;
      err_overrun  <= 1'b0;
      err_timeout  <= 1'b0;
    end else begin
      done <= 1'b0;

      // Acceptance retires the pending write in any state; a word completing
      // in the same cycle overrides this below.
      if (wr_valid && wr_ready) begin
        wr_valid <= 1'b0;
      end

      // Inter-byte watchdog: a byte always wins over expiry.
      if (timed_state) begin
        if (byte_ready) begin
          timer <= TIMER_RELOAD;
        end else if (timer_expired) begin
          err_timeout <= 1'b1;
          state       <= ABORT;
        end else begin
          timer <= timer - TIMER_ONE;
        end
      end

      case (state)
        IDLE: begin
          if (byte_ready && (byte_data == SYNC_BYTE)) begin
            err_checksum <= 1'b0;
            err_overrun  <= 1'b0;
            err_timeout  <= 1'b0;
            csum         <= 8'd0;
            byte_idx     <= 2'd0;
            timer        <= TIMER_RELOAD;
            busy         <= 1'b1;
            state        <= ADDR;
          end
        end

        ADDR: begin
          if (byte_ready) begin
            csum      <= csum_next;
            base_addr <= {byte_data, base_addr[31:8]};
            byte_idx  <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              state <= COUNT;
            end
          end
        end

        COUNT: begin
          if (byte_ready) begin
            csum       <= csum_next;
            word_total <= (byte_data == 8'd0) ? 9'd256 : {1'b0, byte_data};
            word_idx   <= 8'd0;
            byte_idx   <= 2'd0;
            state      <= DATA;
          end
        end

        DATA: begin
          if (byte_ready) begin
            csum     <= csum_next;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx != 2'd3) begin
              word_sr <= {byte_data, word_sr[23:8]};
            end else if (wr_stalled) begin
              // Keep the pending write, drop the new word.
              err_overrun <= 1'b1;
              state       <= ABORT;
            end else begin
              wr_valid <= 1'b1;
              wr_data  <= next_word;
              wr_addr  <= next_addr;
              word_idx <= word_idx + 8'd1;
              if (last_word) begin
                state <= CSUM;
              end
            end
          end
        end

        CSUM: begin
          if (byte_ready) begin
            if (byte_data != csum) begin
              err_checksum <= 1'b1;
            end
            if (wr_stalled) begin
              state <= DRAIN;
            end else begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= IDLE;
            end
          end
        end

        DRAIN: begin
          if (!wr_stalled) begin
            done  <= 1'b1;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        ABORT: begin
          if (!wr_valid) begin
            busy  <= 1'b0;
            state <= IDLE;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mfp_uart_load_controller.sv
// Purpose : directed bench for mfp_uart_load_controller with a write scoreboard.
// Latency : bytes spaced 3 clocks apart unless a step needs otherwise.
// Backpress: wr_ready driven per step to exercise stalls and overrun.
module tb_mfp_uart_load_controller;

  logic        clock;
  logic        reset_n;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        wr_valid;
  logic        wr_ready;
  logic        busy;
  logic        done;
  logic        err_checksum;
  logic        err_overrun;
  logic        err_timeout;

  int total = 0;
  int bad   = 0;
  int done_cnt = 0;

  logic [63:0] exp_q[$];      // {addr, data} of expected writes, in order
  logic [31:0] pkt_words[$];  // payload for the next send_pkt

  mfp_uart_load_controller #(
    .SYNC_BYTE      (8'hA5),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .byte_data    (byte_data),
    .byte_ready   (byte_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .busy         (busy),
    .done         (done),
    .err_checksum (err_checksum),
    .err_overrun  (err_overrun),
    .err_timeout  (err_timeout)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Write scoreboard: every cycle wr_valid is high the presented write must
  // match the oldest expected entry; pop on acceptance.
  always @(negedge clock) begin
    if (reset_n && wr_valid) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {63'd0, wr_valid}, 64'd0);
      end else begin
        check("wr_addr", {32'd0, wr_addr}, {32'd0, exp_q[0][63:32]});
        check("wr_data", {32'd0, wr_data}, {32'd0, exp_q[0][31:0]});
        if (wr_ready) void'(exp_q.pop_front());
      end
    end
    if (reset_n && done) done_cnt++;
  end

  // Caller is always at posedge+1; returns at posedge+1.
  task automatic send_byte(input logic [7:0] b, input int gap);
    byte_data  = b;
    byte_ready = 1'b1;
    @(posedge clock); #1;
    byte_ready = 1'b0;
    repeat (gap) begin
      @(posedge clock); #1;
    end
  endtask

  task automatic send_pkt(input logic [31:0] base, input logic [7:0] cnt,
                          input logic [7:0] csum_adj, input bit push_exp);
    int n;
    logic [7:0] s;
    logic [7:0] b;
    logic [31:0] w;
    n = (cnt == 8'd0) ? 256 : int'(cnt);
    s = 8'd0;
    send_byte(8'hA5, 2);
    for (int i = 0; i < 4; i++) begin
      b = base[8*i +: 8];
      s = s + b;
      send_byte(b, 2);
    end
    s = s + cnt;
    send_byte(cnt, 2);
    for (int i = 0; i < n; i++) begin
      w = pkt_words[i];
      if (push_exp) exp_q.push_back({base + 32'(4 * i), w});
      for (int j = 0; j < 4; j++) begin
        b = w[8*j +: 8];
        s = s + b;
        send_byte(b, 2);
      end
    end
    send_byte(s + csum_adj, 2);
  endtask

  task automatic wait_done(input int target);
    for (int i = 0; i < 50 && done_cnt < target; i++) begin
      @(posedge clock); #1;
    end
    check("done_count", 64'(done_cnt), 64'(target));
  endtask

  initial begin
    int cyc;
    reset_n    = 1'b0;
    byte_data  = 8'h00;
    byte_ready = 1'b0;
    wr_ready   = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    // Reset state
    check("rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done", {63'd0, done}, 64'd0);
    check("rst_flags", {61'd0, err_checksum, err_overrun, err_timeout}, 64'd0);
    check("rst_wr_addr", {32'd0, wr_addr}, 64'd0);
    reset_n = 1'b1;
    @(posedge clock); #1;

    // 1: two-word packet, good checksum, ready always high
    pkt_words = {32'h44332211, 32'h88776655};
    send_pkt(32'h00001000, 8'd2, 8'd0, 1'b1);
    wait_done(1);
    @(posedge clock); #1;
    check("t1_busy", {63'd0, busy}, 64'd0);
    check("t1_flags", {61'd0, err_checksum, err_overrun, err_timeout}, 64'd0);
    check("t1_q_empty", 64'(exp_q.size()), 64'd0);

    // 2: same packet, bad checksum: writes still issued, done pulses
    send_pkt(32'h00001000, 8'd2, 8'd1, 1'b1);
    wait_done(2);
    check("t2_err_checksum", {63'd0, err_checksum}, 64'd1);
    check("t2_q_empty", 64'(exp_q.size()), 64'd0);
    send_byte(8'hA5, 0);
    check("t2_csum_cleared", {63'd0, err_checksum}, 64'd0);
    check("t2_busy_after_sync", {63'd0, busy}, 64'd1);

    // 5: stop after ADDR, timeout exactly 100 cycles after last byte
    send_byte(8'h00, 2);
    send_byte(8'h20, 2);
    send_byte(8'h00, 2);
    send_byte(8'h00, 0);
    cyc = 0;
    while (!err_timeout && cyc < 300) begin
      @(posedge clock); #1;
      cyc++;
    end
    check("t5_timeout_cycles", 64'(cyc), 64'd100);
    @(posedge clock); #1;
    check("t5_busy", {63'd0, busy}, 64'd0);
    check("t5_no_done", 64'(done_cnt), 64'd2);

    // 3: address wrap
    pkt_words = {32'hCAFEF00D};
    send_pkt(32'hFFFFFFFC, 8'd1, 8'd0, 1'b1);
    wait_done(3);
    check("t3_timeout_cleared", {63'd0, err_timeout}, 64'd0);
    pkt_words = {32'h01234567, 32'h89ABCDEF};
    send_pkt(32'hFFFFFFFC, 8'd2, 8'd0, 1'b1);
    wait_done(4);
    check("t3_q_empty", 64'(exp_q.size()), 64'd0);

    // COUNT=0 means 256 words; unaligned base keeps its low bits
    pkt_words.delete();
    for (int i = 0; i < 256; i++) pkt_words.push_back((32'h01010101 * 32'(i)) ^ 32'h5A000000);
    send_pkt(32'h20000002, 8'd0, 8'd0, 1'b1);
    wait_done(5);
    check("t3b_q_empty", 64'(exp_q.size()), 64'd0);
    check("t3b_flags", {61'd0, err_checksum, err_overrun, err_timeout}, 64'd0);

    // 4: overrun: first write stalls across a whole second word
    wr_ready = 1'b0;
    exp_q.push_back({32'h00002000, 32'hDDCCBBAA});
    send_byte(8'hA5, 2);
    send_byte(8'h00, 2); send_byte(8'h20, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    send_byte(8'h02, 2);
    send_byte(8'hAA, 2); send_byte(8'hBB, 2); send_byte(8'hCC, 2); send_byte(8'hDD, 2);
    send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2); send_byte(8'h44, 2);
    check("t4_err_overrun", {63'd0, err_overrun}, 64'd1);
    check("t4_wr_valid_held", {63'd0, wr_valid}, 64'd1);
    check("t4_busy_abort", {63'd0, busy}, 64'd1);
    wr_ready = 1'b1;
    repeat (4) begin
      @(posedge clock); #1;
    end
    check("t4_busy_idle", {63'd0, busy}, 64'd0);
    check("t4_q_empty", 64'(exp_q.size()), 64'd0);
    check("t4_no_done", 64'(done_cnt), 64'd5);

    // 6: garbage ignored, then async reset mid-DATA with a pending write
    wr_ready = 1'b0;
    send_byte(8'h00, 2); send_byte(8'hFF, 2); send_byte(8'h5A, 2);
    check("t6_garbage_busy", {63'd0, busy}, 64'd0);
    exp_q.push_back({32'h00003000, 32'h78563412});
    send_byte(8'hA5, 2);
    send_byte(8'h00, 2); send_byte(8'h30, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    send_byte(8'h02, 2);
    send_byte(8'h12, 2); send_byte(8'h34, 2); send_byte(8'h56, 2); send_byte(8'h78, 2);
    send_byte(8'h9A, 2); send_byte(8'hBC, 0);
    check("t6_wr_valid_pending", {63'd0, wr_valid}, 64'd1);
    exp_q.delete();
    reset_n = 1'b0;
    #1;
    check("t6_rst_wr_valid", {63'd0, wr_valid}, 64'd0);
    check("t6_rst_busy", {63'd0, busy}, 64'd0);
    check("t6_rst_flags", {61'd0, err_checksum, err_overrun, err_timeout}, 64'd0);
    @(posedge clock); #1;
    reset_n  = 1'b1;
    wr_ready = 1'b1;
    @(posedge clock); #1;
    pkt_words = {32'hFEEDBEEF};
    send_pkt(32'h00000040, 8'd1, 8'd0, 1'b1);
    wait_done(6);
    check("t6_recover_q_empty", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
